// File: rtl/slot_reel_display_pkg.sv
// Shared types and constants for the slot reel display: FSM states,
// active-low 7-segment patterns and the reel digit field position.
package slot_pkg;

    typedef enum logic [1:0] {
        SPIN  = 2'd0,
        JUDGE = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_e;

    localparam int DIGIT_LSB = 23;
    localparam int DIGIT_W   = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // The reel counter sits on 10 for a single cycle before wrapping; show it as 0.
    function automatic logic [DIGIT_W-1:0] live_digit(input logic [DIGIT_W-1:0] field);
        return (field > 4'd9) ? 4'd0 : field;
    endfunction

endpackage

// File: rtl/slot_reel_display_seg7_decode.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
// Codes 10..15 produce a blank digit.
module seg7_decode
    import slot_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/slot_reel_display.sv
// Reel digit capture, round judging and multiplexed 3-digit display driver.
// Optional macro SLOT_BLINK_EN adds a blanking blink while in WIN.
module slot_reel_display
    import slot_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 6250000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] reel0,
    input  logic [31:0] reel1,
    input  logic [31:0] reel2,
    input  logic        stop0,
    input  logic        stop1,
    input  logic        stop2,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        win,
    output logic        lose
);

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [2:0]              stop_raw;
    logic [2:0][DIGIT_W-1:0] live;
    logic [2:0][DIGIT_W-1:0] shown;
    logic [2:0]              sync1_q, sync2_q;
    logic [2:0]              lock_q, lock_d;
    logic [2:0][DIGIT_W-1:0] latched_q, latched_d;
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic                    scan_wrap;
    logic [DIGIT_W-1:0]      shown_sel;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_q, seg_d;
    logic [2:0]              an_q, an_d;
    logic                    win_q, lose_q;
    logic                    blank;
    state_e                  state_q;

    logic unused_reel_bits;
    assign unused_reel_bits = ^{reel0[31:27], reel0[22:0],
                                reel1[31:27], reel1[22:0],
                                reel2[31:27], reel2[22:0]};

    assign stop_raw = {stop2, stop1, stop0};
    assign live[0]  = live_digit(reel0[DIGIT_LSB +: DIGIT_W]);
    assign live[1]  = live_digit(reel1[DIGIT_LSB +: DIGIT_W]);
    assign live[2]  = live_digit(reel2[DIGIT_LSB +: DIGIT_W]);

    // A reel locks once, on the first synchronized press; later presses are ignored.
    always_comb begin
        lock_d    = lock_q;
        latched_d = latched_q;
        shown     = live;
        for (int i = 0; i < 3; i++) begin
            if (!sync2_q[i] && !lock_q[i]) begin
                lock_d[i]    = 1'b1;
                latched_d[i] = live[i];
            end
            if (lock_q[i]) begin
                shown[i] = latched_q[i];
            end
        end
    end

    assign scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    assign idx_d      = !scan_wrap ? idx_q : ((idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1);

    always_comb begin
        case (idx_q)
            2'd0:    shown_sel = shown[0];
            2'd1:    shown_sel = shown[1];
            default: shown_sel = shown[2];
        endcase
    end

    seg7_decode u_decode (
        .digit_i (shown_sel),
        .seg_o   (dec_seg)
    );

`ifdef SLOT_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;

    // Blink timer runs only in WIN; the scan keeps going underneath the blank phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (state_q == WIN) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blank = (state_q == WIN) && !blink_on_q;
`else
    localparam int unused_blink_div = BLINK_DIV;
    assign blank = 1'b0;
`endif

    assign seg_d = blank ? SEG_BLANK : dec_seg;
    assign an_d  = blank ? 3'b111 : ~(3'b001 << idx_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 3'b111;
            sync2_q    <= 3'b111;
            lock_q     <= '0;
            latched_q  <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= 3'b111;
        end else begin
            sync1_q    <= stop_raw;
            sync2_q    <= sync1_q;
            lock_q     <= lock_d;
            latched_q  <= latched_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SPIN;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            case (state_q)
                SPIN:    if (&lock_q) state_q <= JUDGE;
                JUDGE:   state_q <= ((latched_q[0] == latched_q[1]) &&
                                     (latched_q[1] == latched_q[2])) ? WIN : LOSE;
                default: state_q <= state_q;
            endcase
            win_q  <= (state_q == WIN);
            lose_q <= (state_q == LOSE);
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign win  = win_q;
    assign lose = lose_q;

endmodule
